// File: rtl/bcd_display_scheduler.sv
// bcd_display_scheduler
//   Time-shares one external BCD-to-7-segment decoder across NUM_DIGITS
//   displays. Each load sequences digits MSB->LSB through the decoder, one
//   TICK_DIV-cycle slot per digit, and latches each returned pattern into
//   that digit's HEX_out field. Leading zeros are optionally blanked.
// Ports
//   CLOCK_50  : clock, rising edge
//   reset     : synchronous, active-high
//   bcd_in    : packed digits, [4i+3:4i] = digit i (digit 0 least significant)
//   load      : one-cycle request to display bcd_in
//   busy      : high for the whole pass
//   pass_done : pulse in the final cycle of a pass
//   dec_bcd   : digit presented to the shared decoder
//   dec_seg   : decoder result, active-low, a..g with a as MSB
//   HEX_out   : registered patterns, [7i+6:7i] drives display i
module bcd_display_scheduler #(
  parameter int NUM_DIGITS    = 4,
  parameter int TICK_DIV      = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  output logic                    busy,
  output logic                    pass_done,
  output logic [3:0]              dec_bcd,
  input  logic [6:0]              dec_seg,
  output logic [7*NUM_DIGITS-1:0] HEX_out
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [IW-1:0] LAST    = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_END = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WAIT} state_t;

  state_t                  state, state_nxt;
  logic [4*NUM_DIGITS-1:0] work, pend;
  logic                    pend_vld;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic                    seen;
  logic [3:0]              dig;
  logic                    slot_end, pass_end, chain;
  logic [6:0]              seg_w;

  // current work digit; work is frozen during a pass so this is stable
  // from ISSUE through CAPTURE
  always_comb begin
    dig = 4'd0;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (idx == IW'(d)) dig = work[4*d +: 4];
  end

  // cnt is the cycle position within the slot; ISSUE is always position 0,
  // so the slot ends in CAPTURE when TICK_DIV=2, otherwise in WAIT
  assign slot_end  = (state == CAPTURE || state == WAIT) && (cnt == CNT_END);
  assign pass_end  = slot_end && (idx == '0);
  assign chain     = pass_end && (pend_vld || load);
  assign busy      = (state != IDLE);
  assign pass_done = pass_end;
  assign dec_bcd   = dig;

  assign seg_w = (BLANK_LEADING != 0 && dig == 4'd0 && !seen && idx != '0)
                 ? 7'h7F : dec_seg;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE,
      WAIT: begin
        if (!slot_end)        state_nxt = WAIT;
        else if (idx != '0)   state_nxt = ISSUE;
        else if (chain)       state_nxt = ISSUE;
        else                  state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      work     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      idx      <= '0;
      cnt      <= '0;
      seen     <= 1'b0;
    end else begin
      state <= state_nxt;
      // counter only advances inside a pass
      cnt   <= (state == IDLE || slot_end) ? '0 : cnt + 1'b1;
      if (state == IDLE && load) begin
        work <= bcd_in;
        idx  <= LAST;
        seen <= 1'b0;
      end else if (chain) begin
        // a load in this very cycle is newer than anything pending
        work     <= load ? bcd_in : pend;
        pend_vld <= 1'b0;
        idx      <= LAST;
        seen     <= 1'b0;
      end else begin
        if (load && state != IDLE) begin
          pend     <= bcd_in;
          pend_vld <= 1'b1;
        end
        if (slot_end && idx != '0) idx <= idx - 1'b1;
        if (state == CAPTURE && dig != 4'd0) seen <= 1'b1;
      end
    end
  end

  // one register per display; a field only changes in its own CAPTURE cycle
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
    always_ff @(posedge CLOCK_50) begin
      if (reset)
        HEX_out[7*g +: 7] <= 7'h7F;
      else if (state == CAPTURE && idx == IW'(g))
        HEX_out[7*g +: 7] <= seg_w;
    end
  end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
module tb_bcd_display_scheduler;
  logic        clk = 1'b0;
  logic        reset, load;
  logic [15:0] bcd_in;
  logic        busy0, pd0, busy1, pd1;
  logic [3:0]  dec0, dec1;
  logic [6:0]  dseg0, dseg1;
  logic [27:0] hex0, hex1;

  int n_vec = 0, n_bad = 0;

  typedef struct { logic [27:0] hb; logic [27:0] hn; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] b);
    case (b)
      4'd0: seg7 = 7'b0000001;  4'd1: seg7 = 7'b1001111;
      4'd2: seg7 = 7'b0010010;  4'd3: seg7 = 7'b0000110;
      4'd4: seg7 = 7'b1001100;  4'd5: seg7 = 7'b0100100;
      4'd6: seg7 = 7'b0100000;  4'd7: seg7 = 7'b0001111;
      4'd8: seg7 = 7'b0000000;  4'd9: seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex(input logic [15:0] v, input bit blank);
    logic [27:0] r;
    logic [3:0]  dg;
    bit          nz;
    r = '1; nz = 0;
    for (int d = 3; d >= 0; d--) begin
      dg = v[4*d +: 4];
      if (blank && dg == 4'd0 && !nz && d != 0) r[7*d +: 7] = 7'h7F;
      else r[7*d +: 7] = seg7(dg);
      if (dg != 4'd0) nz = 1;
    end
    return r;
  endfunction

  assign dseg0 = seg7(dec0);
  assign dseg1 = seg7(dec1);

  bcd_display_scheduler #(.NUM_DIGITS(4), .TICK_DIV(4), .BLANK_LEADING(1)) u_blank (
    .CLOCK_50(clk), .reset(reset), .bcd_in(bcd_in), .load(load),
    .busy(busy0), .pass_done(pd0), .dec_bcd(dec0), .dec_seg(dseg0), .HEX_out(hex0));

  bcd_display_scheduler #(.NUM_DIGITS(4), .TICK_DIV(4), .BLANK_LEADING(0)) u_noblank (
    .CLOCK_50(clk), .reset(reset), .bcd_in(bcd_in), .load(load),
    .busy(busy1), .pass_done(pd1), .dec_bcd(dec1), .dec_seg(dseg1), .HEX_out(hex1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [15:0] v);
    exp_t e;
    e.hb = exp_hex(v, 1);
    e.hn = exp_hex(v, 0);
    sb.push_back(e);
  endtask

  // scoreboard: each pass_done pops the expected final display contents
  always @(negedge clk) begin
    if (reset === 1'b0 && pd0 === 1'b1) begin
      if (sb.size() == 0) chk("unexp_pass", {31'd0, pd0}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("hex_blank", {4'd0, hex0}, {4'd0, e.hb});
        chk("hex_noblank", {4'd0, hex1}, {4'd0, e.hn});
        chk("pd_noblank", {31'd0, pd1}, 32'd1);
      end
    end
  end

  // one load at cycle 0, optional extra loads at cycles ca/cb; np passes expected
  task automatic run_seq(input logic [15:0] v0, input int np, input logic [15:0] v1,
                         input int ca, input logic [15:0] va,
                         input int cb, input logic [15:0] vb);
    logic [15:0] cur;
    int s;
    push(v0);
    if (np == 2) push(v1);
    @(negedge clk); bcd_in = v0; load = 1'b1;
    @(negedge clk); load = 1'b0;
    for (int c = 1; c <= np*16 + 1; c++) begin
      cur = (c <= 16) ? v0 : v1;
      chk("busy", {31'd0, busy0}, {31'd0, c <= np*16});
      chk("pass_done", {31'd0, pd0}, {31'd0, (c == 16) || (c == np*16)});
      if ((c - 1) % 4 == 0 && c <= np*16) begin
        s = ((c - 1) / 4) % 4;
        chk("dec_bcd", {28'd0, dec0}, {28'd0, cur[4*(3-s) +: 4]});
      end
      if (c == ca)      begin bcd_in = va; load = 1'b1; end
      else if (c == cb) begin bcd_in = vb; load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; bcd_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // 1: reset state and idle
    repeat (20) @(negedge clk);
    chk("rst_hex", {4'd0, hex0}, {4'd0, 28'hFFFFFFF});
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_pd", {31'd0, pd0}, 32'd0);
    chk("rst_dec", {28'd0, dec0}, 32'd0);
    chk("rst_hex_nb", {4'd0, hex1}, {4'd0, 28'hFFFFFFF});

    // 2/3: 0042 with and without blanking
    run_seq(16'h0042, 1, 16'h0, 0, 16'h0, 0, 16'h0);
    chk("hex_0042", {4'd0, hex0}, {4'd0, 7'b1111111, 7'b1111111, 7'b1001100, 7'b0010010});
    chk("hex_0042_nb", {4'd0, hex1}, {4'd0, 7'b0000001, 7'b0000001, 7'b1001100, 7'b0010010});

    // 4: pending loads, last one wins, back-to-back passes
    run_seq(16'h1234, 2, 16'h9001, 6, 16'h5678, 10, 16'h9001);

    // 5: all zeros, then invalid code counting as nonzero
    run_seq(16'h0000, 1, 16'h0, 0, 16'h0, 0, 16'h0);
    run_seq(16'h00A5, 1, 16'h0, 0, 16'h0, 0, 16'h0);
    chk("hex_00A5", {4'd0, hex0}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'b0100100});

    // 6: reset mid-pass with a load pending
    @(negedge clk); bcd_in = 16'h1234; load = 1'b1;
    @(negedge clk); load = 1'b0;                       // cycle 1
    for (int c = 1; c < 7; c++) begin
      if (c == 3) begin bcd_in = 16'h5678; load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1;                                      // sampled at end of cycle 7
    sb.delete();
    @(negedge clk); reset = 1'b0;
    chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
    chk("mid_rst_pd", {31'd0, pd0}, 32'd0);
    chk("mid_rst_hex", {4'd0, hex0}, {4'd0, 28'hFFFFFFF});
    chk("mid_rst_hex_nb", {4'd0, hex1}, {4'd0, 28'hFFFFFFF});
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy0}, 32'd0);
    end
    chk("post_rst_hex", {4'd0, hex0}, {4'd0, 28'hFFFFFFF});
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
